// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Packs a little-endian boot byte stream into DATA_WIDTH-bit words
//            and writes them to consecutive instruction-memory addresses.
//            Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECV   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [1:0] S_CHECK  = 2'd3;
  localparam logic [1:0] S_AFTER  = S_CHECK;
`else
  localparam logic [1:0] S_AFTER  = S_FINISH;
`endif

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  write_en_q, write_en_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic w_accept, w_last_byte, w_last_word, w_start_idle;

  assign w_accept     = byte_valid & byte_ready_q;
  assign w_last_byte  = (byte_cnt_q == BCW'(BYTES - 1));
  assign w_last_word  = (word_cnt_q == len_q - LEN_WIDTH'(1));
  assign w_start_idle = (state_q == S_IDLE) && start;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start && (length != '0)) state_d = S_RECV;
      S_RECV:   if (w_accept && w_last_byte && w_last_word) state_d = S_AFTER;
      S_FINISH: state_d = S_IDLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK:  if (w_accept) state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    base_d       = base_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    write_en_d   = 1'b0;
    done_d       = 1'b0;

    if (w_start_idle) begin
      if (length != '0) begin
        base_d     = base_addr;
        len_d      = length;
        word_cnt_d = '0;
        byte_cnt_d = '0;
      end else begin
        done_d = 1'b1;
      end
    end

    if ((state_q == S_RECV) && w_accept) begin
      asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
      if (w_last_byte) begin
        byte_cnt_d   = '0;
        word_cnt_d   = word_cnt_q + 1'b1;
        write_en_d   = 1'b1;
        write_addr_d = base_q + word_cnt_q[ADDR_WIDTH-1:0];
        write_data_d = asm_d;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end

    if (state_q == S_FINISH) done_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if ((state_q == S_CHECK) && w_accept) done_d = 1'b1;
    byte_ready_d = (state_d == S_RECV) || (state_d == S_CHECK);
`else
    byte_ready_d = (state_d == S_RECV);
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q       <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      write_addr_q <= '0;
      write_data_q <= '0;
      write_en_q   <= 1'b0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      base_q       <= base_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      write_en_q   <= write_en_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       error_q, error_d;

  // Running sum covers data bytes only; the verdict is held until the next start
  always_comb begin
    sum_d   = sum_q;
    error_d = error_q;
    if (w_start_idle) begin
      sum_d   = '0;
      error_d = 1'b0;
    end
    if ((state_q == S_RECV) && w_accept) sum_d = sum_q + byte_data;
    if ((state_q == S_CHECK) && w_accept) error_d = (byte_data != sum_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q   <= '0;
      error_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign byte_ready = byte_ready_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign write_en   = write_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory.
- Receives a program as a byte stream from the boot/debug link.
- Assembles bytes little-endian into DATA_WIDTH-bit words.
- Drives the memory write port (write_addr, write_data, write_en) with consecutive addresses starting at a base address.
- Signals completion to the core reset/boot controller, which holds the core in reset until done.

Parameters:
ADDR_WIDTH, 10, word address width of the instruction memory.
DATA_WIDTH, 32, memory word width; must be a multiple of 8; BYTES = DATA_WIDTH/8.
LEN_WIDTH, ADDR_WIDTH+1, width of the word-count input; allows a full 2^ADDR_WIDTH load.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  begin a load; sampled only in IDLE.
base_addr  in  ADDR_WIDTH  first word address; captured on start.
length  in  LEN_WIDTH  number of words to load; captured on start.
byte_valid  in  1  byte_data valid.
byte_data  in  8  stream byte.
byte_ready  out  1  loader accepts a byte; a transfer occurs when byte_valid & byte_ready.
write_addr  out  ADDR_WIDTH  memory write address.
write_data  out  DATA_WIDTH  memory write data.
write_en  out  1  one-cycle memory write strobe.
busy  out  1  load in progress.
done  out  1  one-cycle pulse at end of load.
error  out  1  checksum mismatch; valid with done; see Optional Feature.

Behaviour:
- Reset values: byte_ready=0, write_en=0, write_addr=0, write_data=0, busy=0, done=0, error=0. Internal counters=0. State=IDLE.
- Reset mid-load: aborts immediately. Partial word is discarded. No further write_en. No done pulse.
- All outputs are registered.
- State IDLE:
  - byte_ready=0.
  - start=1 and length!=0: capture base_addr/length, clear byte and word counters, enter RECV, busy=1 from the next cycle.
  - start=1 and length=0: no writes; done pulses in the next cycle; stay IDLE.
- State RECV:
  - byte_ready=1 continuously, including cycles where write_en is high, so back-to-back streaming has no bubbles.
  - Byte k (k=0..BYTES-1) is stored in write_data bits [8k+7:8k].
  - When byte BYTES-1 is accepted in cycle N: write_en=1 in cycle N+1 with write_addr = base + word_index (mod 2^ADDR_WIDTH) and the full word on write_data. Word index increments.
  - byte_valid gaps stall assembly; no timeout.
- Last word: when the final byte of word length-1 is accepted in cycle N:
  - enter FINISH; byte_ready=0 from N+1; write_en=1 in N+1.
  - done=1 and busy=0 in N+2; return to IDLE.
  - Without the optional feature, error stays 0.
- Address wrap: base_addr=2^ADDR_WIDTH-1 wraps to 0 for the next word; no error.
- start while busy is ignored.
- Bytes offered while byte_ready=0 are not consumed.
- write_addr/write_data hold their last values when write_en=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last word, the FSM enters CHECK instead of FINISH; byte_ready stays 1 for exactly one more byte.
  - That byte is compared with the 8-bit modulo-256 sum of all data bytes (sum cleared on start).
  - If the checksum byte is accepted in cycle M: done=1 and busy=0 in M+1; error = (mismatch), held until the next accepted start or reset.
  - Data words are written regardless of checksum outcome.
  - With length=0, no checksum byte is expected and error=0.
- When not defined: no CHECK state, no sum logic, error tied to 0.

Test Plan:
- Basic load: base 0x010, length 2, bytes 11 22 33 44 55 66 77 88 streamed every cycle -> write_en at 0x010 data 0x44332211, then 0x011 data 0x88776655; done 2 cycles after byte 88; never more than one write per word.
- Backpressure: same stream with random byte_valid gaps -> identical writes; write_en exactly 1 cycle after each 4th byte accepted.
- Wrap: base 0x3FF, length 2 -> writes at 0x3FF then 0x000.
- Zero length and start-while-busy:
  - length 0 -> done next cycle, no write_en, byte_ready stays 0.
  - start pulsed mid-load -> ignored, load completes normally.
- Reset mid-load: reset after 6 of 8 bytes -> one write only (first word); outputs return to reset values; no done; a new load afterwards works.
- Checksum (macro on): bytes 01 02 03 04 + checksum 0x0A -> done with error=0; checksum 0x0B -> done with error=1, word 0x04030201 still written.
